// File: rtl/mat_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mat_scan_driver: scans a 4x14 RGB matrix panel (shift, latch, display/row).
// Rev 1.0
// ----------------------------------------------------------------------------
module mat_scan_driver #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DWELL   = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] col,
   output logic [5:0] sel,
   output logic       sdat_r,
   output logic       sdat_g,
   output logic       sdat_b,
   output logic       sclk,
   output logic       lat,
   output logic       oe_n,
   output logic [1:0] row,
   output logic       frame_done
);

   localparam int unsigned c_NUM_COLS     = 14;
   localparam logic [3:0]  c_LAST_COL     = 4'd13;
   localparam logic [1:0]  c_LAST_ROW     = 2'd3;
   localparam logic [7:0]  c_DIV_RELOAD   = 8'(CLK_DIV - 1);
   localparam logic [15:0] c_DWELL_RELOAD = 16'(DWELL - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      LATCH    = 3'd4,
      DISPLAY  = 3'd5
   } state_t;

   // Reset asserts asynchronously but is released to the FSM two edges later.
   logic [1:0] rst_sync_q;
   logic       run_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign run_en = rst_sync_q[1];

   state_t      state_q, state_d;
   logic [3:0]  column_q, column_d;
   logic [1:0]  shift_row_q, shift_row_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic [15:0] dwell_cnt_q, dwell_cnt_d;
   logic [2:0]  sdat_q, sdat_d;
   logic        sclk_q, sclk_d;
   logic        lat_q, lat_d;
   logic        oe_n_q, oe_n_d;
   logic [1:0]  row_q, row_d;
   logic        frame_done_q, frame_done_d;

   always_comb begin
      state_d      = state_q;
      column_d     = column_q;
      shift_row_d  = shift_row_q;
      sdat_d       = sdat_q;
      row_d        = row_q;
      frame_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d     = LOAD;
               column_d    = 4'd0;
               shift_row_d = 2'd0;
            end
         end
         LOAD: begin
            sdat_d  = col;
            state_d = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (div_cnt_q == 8'd0) state_d = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (div_cnt_q == 8'd0) begin
               if (column_q < c_LAST_COL) begin
                  column_d = column_q + 4'd1;
                  state_d  = LOAD;
               end else begin
                  column_d = 4'd0;
                  row_d    = shift_row_q;
                  state_d  = LATCH;
               end
            end
         end
         LATCH: begin
            if (div_cnt_q == 8'd0) state_d = DISPLAY;
         end
         DISPLAY: begin
            if (dwell_cnt_q == 16'd0) begin
               if (shift_row_q != c_LAST_ROW) begin
                  shift_row_d = shift_row_q + 2'd1;
                  state_d     = LOAD;
               end else begin
                  frame_done_d = 1'b1;
                  shift_row_d  = 2'd0;
                  state_d      = en ? LOAD : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Both counters restart whenever the state changes, so every timed
      // state sees a fresh count regardless of which state preceded it.
      if (state_d != state_q) begin
         div_cnt_d   = c_DIV_RELOAD;
         dwell_cnt_d = c_DWELL_RELOAD;
      end else begin
         div_cnt_d   = div_cnt_q - 8'(div_cnt_q != 8'd0);
         dwell_cnt_d = dwell_cnt_q - 16'(dwell_cnt_q != 16'd0);
      end

      if (!run_en) begin
         state_d      = IDLE;
         column_d     = 4'd0;
         shift_row_d  = 2'd0;
         div_cnt_d    = 8'd0;
         dwell_cnt_d  = 16'd0;
         sdat_d       = 3'd0;
         row_d        = 2'd0;
         frame_done_d = 1'b0;
      end

      // Panel strobes are registered from the next state to keep them glitch-free.
      sclk_d = (state_d == SHIFT_HI);
      lat_d  = (state_d == LATCH);
      oe_n_d = (state_d != DISPLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         column_q     <= 4'd0;
         shift_row_q  <= 2'd0;
         div_cnt_q    <= 8'd0;
         dwell_cnt_q  <= 16'd0;
         sdat_q       <= 3'd0;
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         row_q        <= 2'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         column_q     <= column_d;
         shift_row_q  <= shift_row_d;
         div_cnt_q    <= div_cnt_d;
         dwell_cnt_q  <= dwell_cnt_d;
         sdat_q       <= sdat_d;
         sclk_q       <= sclk_d;
         lat_q        <= lat_d;
         oe_n_q       <= oe_n_d;
         row_q        <= row_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign sel        = 6'(shift_row_q) * 6'(c_NUM_COLS) + 6'(column_q);
   assign sdat_r     = sdat_q[2];
   assign sdat_g     = sdat_q[1];
   assign sdat_b     = sdat_q[0];
   assign sclk       = sclk_q;
   assign lat        = lat_q;
   assign oe_n       = oe_n_q;
   assign row        = row_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mat_scan_driver: randomized frames checked against an event scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mat_scan_driver;

   localparam int CD        = 3;
   localparam int DW        = 5;
   localparam int ROW_CYC   = 14 * (1 + 2 * CD) + CD + DW;
   localparam int FRAME_CYC = 4 * ROW_CYC;

   typedef enum int {EV_SHIFT = 0, EV_LATCH = 1, EV_FRAME = 2} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       value;
      int       rgb;
   } ev_t;

   ev_t exp_q[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [2:0] col;
   logic [5:0] sel;
   logic       sdat_r, sdat_g, sdat_b;
   logic       sclk, lat, oe_n;
   logic [1:0] row;
   logic       frame_done;

   logic [2:0] tbl [64];
   assign col = tbl[sel];

   mat_scan_driver #(.CLK_DIV(CD), .DWELL(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .col        (col),
      .sel        (sel),
      .sdat_r     (sdat_r),
      .sdat_g     (sdat_g),
      .sdat_b     (sdat_b),
      .sclk       (sclk),
      .lat        (lat),
      .oe_n       (oe_n),
      .row        (row),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int front_kind();
      return (exp_q.size() != 0) ? int'(exp_q[0].kind) : -1;
   endfunction

   // Reference model: a frame is 4 rows of 14 shifted cells, each row
   // followed by a latch of that row, then one end-of-frame pulse.
   task automatic push_frame(input int mode);
      ev_t e;
      for (int i = 0; i < 56; i++) begin
         if (mode == 0)      tbl[i] = 3'(i % 8);
         else if (mode == 1) tbl[i] = 3'd7;
         else                tbl[i] = 3'($urandom_range(0, 7));
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 14; c++) begin
            e.kind = EV_SHIFT; e.value = r * 14 + c; e.rgb = int'(tbl[r * 14 + c]);
            exp_q.push_back(e);
         end
         e.kind = EV_LATCH; e.value = r; e.rgb = 0;
         exp_q.push_back(e);
      end
      e.kind = EV_FRAME; e.value = 0; e.rgb = 0;
      exp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge and matches panel events in order.
   ev_t mon_e;
   logic p_sclk = 1'b0, p_lat = 1'b0, p_oe_n = 1'b1, p_fd = 1'b0;
   int   t_rise = 0, t_lat = 0, t_oe = 0;
   int   rgb_rise = 0;

   always @(negedge clk) begin
      cyc++;
      if (mon_on && rst_n) begin
         if (sclk && !p_sclk) begin
            chk("shift event order", front_kind(), EV_SHIFT);
            if (front_kind() == EV_SHIFT) begin
               mon_e = exp_q.pop_front();
               chk("sel at sclk rise", sel, mon_e.value);
               chk("rgb at sclk rise", {sdat_r, sdat_g, sdat_b}, mon_e.rgb);
               if (mon_e.value % 14 != 0) chk("sclk rise-to-rise", cyc - t_rise, 2 * CD + 1);
            end
            t_rise   = cyc;
            rgb_rise = {sdat_r, sdat_g, sdat_b};
         end
         if (!sclk && p_sclk) begin
            chk("sclk high length", cyc - t_rise, CD);
            chk("sdat stable over sclk high", {sdat_r, sdat_g, sdat_b}, rgb_rise);
         end
         if (lat && !p_lat) begin
            chk("latch event order", front_kind(), EV_LATCH);
            if (front_kind() == EV_LATCH) begin
               mon_e = exp_q.pop_front();
               chk("row at latch", row, mon_e.value);
            end
            chk("lat after last sclk rise", cyc - t_rise, CD);
            t_lat = cyc;
         end
         if (!lat && p_lat) chk("lat high length", cyc - t_lat, CD);
         if (!oe_n && p_oe_n) begin
            chk("oe_n fall after lat", cyc - t_lat, CD);
            t_oe = cyc;
         end
         if (oe_n && !p_oe_n) chk("oe_n low length", cyc - t_oe, DW);
         if (!oe_n) chk("sclk/lat quiet while lit", {sclk, lat}, 0);
         if (frame_done) begin
            chk("frame_done single cycle", p_fd, 0);
            if (!p_fd) begin
               chk("frame event order", front_kind(), EV_FRAME);
               if (front_kind() == EV_FRAME) mon_e = exp_q.pop_front();
            end
         end
      end
      p_sclk = sclk;
      p_lat  = lat;
      p_oe_n = oe_n;
      p_fd   = frame_done;
   end

   task automatic wait_fd(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 2 * FRAME_CYC);
      chk("frame_done within budget", frame_done, 1);
      t = int'($time / 10);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " sel"}, sel, 0);
      chk({tag, " row"}, row, 0);
      chk({tag, " sdat"}, {sdat_r, sdat_g, sdat_b}, 0);
      chk({tag, " sclk"}, sclk, 0);
      chk({tag, " lat"}, lat, 0);
      chk({tag, " oe_n"}, oe_n, 1);
      chk({tag, " frame_done"}, frame_done, 0);
   endtask

   initial begin
      #(20000 * 10);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, t3, n;
      foreach (tbl[i]) tbl[i] = 3'd0;

      // Power-on reset and idle with en low.
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n  = 1'b1;
      mon_on = 1'b1;
      repeat (12) @(negedge clk);
      chk("idle sclk", sclk, 0);
      chk("idle oe_n", oe_n, 1);

      // Back-to-back frames: sel pattern, random, all-white.
      push_frame(0);
      en = 1'b1;
      wait_fd(t0);
      push_frame(2);
      wait_fd(t1);
      chk("frame period 1", t1 - t0, FRAME_CYC);
      push_frame(1);
      wait_fd(t2);
      chk("frame period 2", t2 - t1, FRAME_CYC);

      // Drop en during row 1; the frame still completes, then the scan stops.
      push_frame(2);
      n = 0;
      do begin @(negedge clk); n++; end while (sel < 6'd14 && n < FRAME_CYC);
      chk("reached row 1", int'(sel >= 6'd14), 1);
      en = 1'b0;
      wait_fd(t3);
      chk("frame period 3", t3 - t2, FRAME_CYC);
      repeat (30) @(negedge clk);
      chk("stopped sclk", sclk, 0);
      chk("stopped oe_n", oe_n, 1);
      chk("stopped queue empty", exp_q.size(), 0);

      // Asynchronous reset during SHIFT_HI of row 2.
      push_frame(2);
      en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(sel >= 6'd28 && sclk) && n < 2 * FRAME_CYC);
      chk("reached row 2 shift high", int'(sel >= 6'd28 && sclk), 1);
      #2;
      exp_q.delete();
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post-reset sclk", sclk, 0);
      chk("post-reset oe_n", oe_n, 1);

      // Recovery: a short en pulse starts exactly one full frame.
      push_frame(2);
      en = 1'b1;
      repeat (5) @(negedge clk);
      en = 1'b0;
      wait_fd(t0);
      repeat (20) @(negedge clk);
      chk("final queue empty", exp_q.size(), 0);
      chk("final oe_n", oe_n, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
